// File: rtl/md_issue_ctrl_pkg.sv
// Shared opcode/state types and MD-unit latency constants for the
// multiply/divide issue controller.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_MFHI  = 3'd6,
      MD_MFLO  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_READ  = 2'd3
   } md_state_e;

   // Busy cycles the MD unit reports after a start, per op class.
   localparam int MD_LAT_MUL = 5;
   localparam int MD_LAT_DIV = 10;
   localparam int MD_LAT_MT  = 1;

   function automatic logic is_read_op(input md_op_e op);
      return (op == MD_MFHI) || (op == MD_MFLO);
   endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline request/read-back and MD-unit start/busy/HI/LO signals.
// master = issue controller, slave = pipeline plus MD unit.
interface md_issue_ctrl_if;
   import md_pkg::*;

   logic        req_valid;
   md_op_e      req_op;
   logic [31:0] req_rs;
   logic [31:0] req_rt;
   logic        req_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        md_start;
   logic [2:0]  md_opt;
   logic [31:0] md_v1;
   logic [31:0] md_v2;
   logic        md_busy;
   logic [31:0] md_hi;
   logic [31:0] md_lo;
   logic        err_timeout;

   modport master (
      input  req_valid, req_op, req_rs, req_rt, md_busy, md_hi, md_lo,
      output req_ready, rd_valid, rd_data, md_start, md_opt, md_v1, md_v2, err_timeout
   );

   modport slave (
      output req_valid, req_op, req_rs, req_rt, md_busy, md_hi, md_lo,
      input  req_ready, rd_valid, rd_data, md_start, md_opt, md_v1, md_v2, err_timeout
   );

endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit: issues start pulses,
// covers the start->busy gap, returns HI/LO reads and flags hung ops.
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            reset,
   md_issue_ctrl_if.master bus
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   md_state_e     state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          start_r, start_s;
   logic [2:0]    opt_r, opt_s;
   logic [31:0]   v1_r, v1_s;
   logic [31:0]   v2_r, v2_s;
   logic          rd_valid_r, rd_valid_s;
   logic [31:0]   rd_data_r, rd_data_s;
   logic          err_r, err_s;
   logic          ready_s;
   logic          accept_s;

   // A busy MD unit seen in IDLE blocks new requests until it drops.
   assign ready_s  = (state_r == ST_IDLE) && !bus.md_busy && !reset;
   assign accept_s = bus.req_valid && ready_s;

   // Next-state and next-output logic for the issue FSM.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      start_s    = 1'b0;
      opt_s      = opt_r;
      v1_s       = v1_r;
      v2_s       = v2_r;
      rd_valid_s = 1'b0;
      rd_data_s  = rd_data_r;
      err_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (is_read_op(bus.req_op)) begin
                  state_s    = ST_READ;
                  rd_valid_s = 1'b1;
                  rd_data_s  = (bus.req_op == MD_MFHI) ? bus.md_hi : bus.md_lo;
               end else begin
                  state_s = ST_ISSUE;
                  start_s = 1'b1;
                  opt_s   = bus.req_op;
                  v1_s    = bus.req_rs;
                  v2_s    = bus.req_rt;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         // Busy is not yet visible here, so it is deliberately not looked at.
         ST_ISSUE: begin
            state_s = ST_WAIT;
            cnt_s   = {CW{1'b0}};
         end
         ST_WAIT: begin
            if (bus.md_busy) begin
               if (cnt_r == CNT_LAST) begin
                  state_s = ST_IDLE;
                  cnt_s   = {CW{1'b0}};
                  err_s   = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               state_s = ST_IDLE;
               cnt_s   = {CW{1'b0}};
            end
         end
         ST_READ: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CW{1'b0}};
         start_r    <= 1'b0;
         opt_r      <= 3'd0;
         v1_r       <= 32'd0;
         v2_r       <= 32'd0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= 32'd0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         start_r    <= start_s;
         opt_r      <= opt_s;
         v1_r       <= v1_s;
         v2_r       <= v2_s;
         rd_valid_r <= rd_valid_s;
         rd_data_r  <= rd_data_s;
         err_r      <= err_s;
      end
   end

   assign bus.req_ready   = ready_s;
   assign bus.md_start    = start_r;
   assign bus.md_opt      = opt_r;
   assign bus.md_v1       = v1_r;
   assign bus.md_v2       = v2_r;
   assign bus.rd_valid    = rd_valid_r;
   assign bus.rd_data     = rd_data_r;
   assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a behavioural MD-unit stub
// and a queue of expected HI/LO read results.
module tb_md_issue_ctrl;
   import md_pkg::*;

   logic clk;
   logic reset;
   logic stuck;
   int   total;
   int   bad;
   logic [31:0] exp_q[$];

   md_issue_ctrl_if bus ();

   md_issue_ctrl #(.TIMEOUT(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // MD-unit stub: busy for the op's latency starting the cycle after start,
   // HI/LO updated on the edge busy falls.
   logic [3:0]  busy_cnt;
   md_op_e      pend_op;
   logic [31:0] pv1, pv2, hi_r, lo_r;

   function automatic logic [63:0] md_calc(input md_op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
      logic signed [63:0] sa, sb;
      logic signed [31:0] qa, qb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      qa = a;
      qb = b;
      case (op)
         MD_MULT:  return sa * sb;
         MD_MULTU: return {32'd0, a} * {32'd0, b};
         MD_DIV:   return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(qa % qb), 32'(qa / qb)};
         MD_DIVU:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         MD_MTHI:  return {a, lo};
         MD_MTLO:  return {hi, a};
         default:  return {hi, lo};
      endcase
   endfunction

   function automatic logic [3:0] md_lat(input md_op_e op);
      case (op)
         MD_MULT, MD_MULTU: return 4'(MD_LAT_MUL);
         MD_DIV, MD_DIVU:   return 4'(MD_LAT_DIV);
         default:           return 4'(MD_LAT_MT);
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_cnt <= 4'd0;
         pend_op  <= MD_MULT;
         pv1      <= 32'd0;
         pv2      <= 32'd0;
         hi_r     <= 32'd0;
         lo_r     <= 32'd0;
      end else if (bus.md_start) begin
         pend_op  <= md_op_e'(bus.md_opt);
         pv1      <= bus.md_v1;
         pv2      <= bus.md_v2;
         busy_cnt <= md_lat(md_op_e'(bus.md_opt));
      end else if (busy_cnt != 4'd0) begin
         busy_cnt <= busy_cnt - 4'd1;
         if (busy_cnt == 4'd1) begin
            {hi_r, lo_r} <= md_calc(pend_op, pv1, pv2, hi_r, lo_r);
         end
      end
   end

   assign bus.md_busy = stuck || (busy_cnt != 4'd0);
   assign bus.md_hi   = hi_r;
   assign bus.md_lo   = lo_r;

   // Presents a request from a negedge and returns at the negedge after the accept edge.
   task automatic send(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic ok);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rs    = rs;
      bus.req_rt    = rt;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_ready(output int lat);
      lat = 0;
      while (!bus.req_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      logic ok;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.req_ready, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2, bus.rd_valid,
           bus.rd_data, bus.err_timeout} !== 103'd0) begin
         bad++;
         $display("FAIL reset_outs: got ready=%b start=%b opt=%0d v1=%h v2=%h rdv=%b rd=%h err=%b want all 0",
                  bus.req_ready, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2, bus.rd_valid,
                  bus.rd_data, bus.err_timeout);
      end
      reset = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_release: got %b want 1", bus.req_ready);
      end
      @(negedge clk);
      send(MD_MULTU, 32'h1111_2222, 32'h3333_4444, ok);
      total++;
      if ({ok, bus.md_start, bus.md_opt} !== {1'b1, 1'b1, 3'd1}) begin
         bad++;
         $display("FAIL issue_before_reset: got ok=%b start=%b opt=%0d want 1 1 1",
                  ok, bus.md_start, bus.md_opt);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({bus.req_ready, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2, bus.rd_valid,
           bus.rd_data, bus.err_timeout} !== 103'd0) begin
         bad++;
         $display("FAIL reset_mid_issue: got ready=%b start=%b opt=%0d v1=%h v2=%h want all 0",
                  bus.req_ready, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.req_ready, bus.md_start} !== 2'b10) begin
         bad++;
         $display("FAIL ready_after_abort: got ready=%b start=%b want 1 0", bus.req_ready, bus.md_start);
      end
   endtask

   task automatic test_mult;
      logic ok;
      int lat, w;
      logic [31:0] exp;
      send(MD_MULT, 32'hFFFF_FFFD, 32'd7, ok);
      total++;
      if ({ok, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2} !== {1'b1, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7}) begin
         bad++;
         $display("FAIL mult_issue: got ok=%b start=%b opt=%0d v1=%h v2=%h want 1 1 0 fffffffd 00000007",
                  ok, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2);
      end
      @(negedge clk);
      total++;
      if ({bus.md_start, bus.md_opt, bus.md_v1} !== {1'b0, 3'd0, 32'hFFFF_FFFD}) begin
         bad++;
         $display("FAIL mult_start_pulse: got start=%b opt=%0d v1=%h want 0 0 fffffffd",
                  bus.md_start, bus.md_opt, bus.md_v1);
      end
      wait_ready(lat);
      total++;
      if (lat + 1 != 2 + MD_LAT_MUL) begin
         bad++;
         $display("FAIL mult_latency: got %0d want %0d", lat + 1, 2 + MD_LAT_MUL);
      end
      exp_q.push_back(32'hFFFF_FFEB);
      send(MD_MFLO, 32'd0, 32'd0, ok);
      w = 0;
      while (!bus.rd_valid && w < 10) begin
         @(negedge clk);
         w++;
      end
      exp = exp_q.pop_front();
      total++;
      if ({bus.rd_valid, bus.md_start, bus.rd_data} !== {1'b1, 1'b0, exp} || w != 0) begin
         bad++;
         $display("FAIL mflo_after_mult: got rdv=%b start=%b data=%h wait=%0d want 1 0 %h 0",
                  bus.rd_valid, bus.md_start, bus.rd_data, w, exp);
      end
      @(negedge clk);
      total++;
      if ({bus.rd_valid, bus.req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL mflo_one_cycle: got rdv=%b ready=%b want 0 1", bus.rd_valid, bus.req_ready);
      end
   endtask

   task automatic test_divu_hold;
      int lat, early;
      logic [31:0] exp;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_DIVU;
      bus.req_rs    = 32'd100;
      bus.req_rt    = 32'd7;
      @(negedge clk);
      total++;
      if ({bus.md_start, bus.md_opt} !== {1'b1, 3'd3}) begin
         bad++;
         $display("FAIL divu_issue: got start=%b opt=%0d want 1 3", bus.md_start, bus.md_opt);
      end
      bus.req_op = MD_MFHI;
      exp_q.push_back(32'd2);
      lat   = 0;
      early = 0;
      while (!bus.req_ready && lat < 100) begin
         @(negedge clk);
         lat++;
         if (bus.rd_valid) early++;
      end
      total++;
      if (lat != 2 + MD_LAT_DIV || early != 0) begin
         bad++;
         $display("FAIL divu_latency: got lat=%0d early_reads=%0d want %0d 0", lat, early, 2 + MD_LAT_DIV);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      exp = exp_q.pop_front();
      total++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp}) begin
         bad++;
         $display("FAIL mfhi_held: got rdv=%b data=%h want 1 %h", bus.rd_valid, bus.rd_data, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_mt;
      logic ok;
      int lat, w;
      logic [31:0] exp;
      send(MD_MTHI, 32'hDEAD_BEEF, 32'd0, ok);
      total++;
      if ({ok, bus.md_start, bus.md_opt, bus.md_v1} !== {1'b1, 1'b1, 3'd4, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL mthi_issue: got ok=%b start=%b opt=%0d v1=%h want 1 1 4 deadbeef",
                  ok, bus.md_start, bus.md_opt, bus.md_v1);
      end
      wait_ready(lat);
      total++;
      if (lat != 2 + MD_LAT_MT) begin
         bad++;
         $display("FAIL mthi_latency: got %0d want %0d", lat, 2 + MD_LAT_MT);
      end
      send(MD_MTLO, 32'h0BAD_F00D, 32'd0, ok);
      total++;
      if ({ok, bus.md_opt} !== {1'b1, 3'd5}) begin
         bad++;
         $display("FAIL mtlo_issue: got ok=%b opt=%0d want 1 5", ok, bus.md_opt);
      end
      wait_ready(lat);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(k == 0 ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
         send(k == 0 ? MD_MFHI : MD_MFLO, 32'd0, 32'd0, ok);
         w = 0;
         while (!bus.rd_valid && w < 10) begin
            @(negedge clk);
            w++;
         end
         exp = exp_q.pop_front();
         total++;
         if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL mf_after_mt%0d: got rdv=%b data=%h want 1 %h", k, bus.rd_valid, bus.rd_data, exp);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic ok;
      int c, c2, overlap, lat, w;
      logic [31:0] exp;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MULT;
      bus.req_rs    = 32'd6;
      bus.req_rt    = 32'hFFFF_FFFB;
      @(negedge clk);
      total++;
      if (bus.md_start !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_start: got %b want 1", bus.md_start);
      end
      bus.req_op = MD_DIV;
      bus.req_rs = 32'd50;
      bus.req_rt = 32'hFFFF_FFF9;
      c = 0;
      c2 = -1;
      overlap = 0;
      while (c < 60 && c2 < 0) begin
         @(negedge clk);
         c++;
         if (bus.md_start && bus.md_busy) overlap++;
         if (bus.md_start) c2 = c;
      end
      bus.req_valid = 1'b0;
      total++;
      if (c2 != MD_LAT_MUL + 3 || overlap != 0) begin
         bad++;
         $display("FAIL b2b_spacing: got gap=%0d overlap=%0d want %0d 0", c2, overlap, MD_LAT_MUL + 3);
      end
      total++;
      if ({bus.md_opt, bus.md_v1, bus.md_v2} !== {3'd2, 32'd50, 32'hFFFF_FFF9}) begin
         bad++;
         $display("FAIL b2b_div_operands: got opt=%0d v1=%h v2=%h want 2 00000032 fffffff9",
                  bus.md_opt, bus.md_v1, bus.md_v2);
      end
      wait_ready(lat);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(k == 0 ? 32'hFFFF_FFF9 : 32'd1);
         send(k == 0 ? MD_MFLO : MD_MFHI, 32'd0, 32'd0, ok);
         w = 0;
         while (!bus.rd_valid && w < 10) begin
            @(negedge clk);
            w++;
         end
         exp = exp_q.pop_front();
         total++;
         if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL div_result%0d: got rdv=%b data=%h want 1 %h", k, bus.rd_valid, bus.rd_data, exp);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_div_zero;
      logic ok;
      int lat;
      send(MD_DIV, 32'd9, 32'd0, ok);
      total++;
      if ({ok, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2} !== {1'b1, 1'b1, 3'd2, 32'd9, 32'd0}) begin
         bad++;
         $display("FAIL div_zero_issue: got ok=%b start=%b opt=%0d v1=%h v2=%h want 1 1 2 9 0",
                  ok, bus.md_start, bus.md_opt, bus.md_v1, bus.md_v2);
      end
      wait_ready(lat);
      total++;
      if (lat != 2 + MD_LAT_DIV || bus.err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL div_zero_latency: got lat=%0d err=%b want %0d 0", lat, bus.err_timeout, 2 + MD_LAT_DIV);
      end
   endtask

   task automatic test_timeout;
      logic ok;
      int c;
      send(MD_MULT, 32'd3, 32'd4, ok);
      stuck = 1'b1;
      c = 0;
      while (!bus.err_timeout && c < 100) begin
         @(negedge clk);
         c++;
      end
      total++;
      if (c != 33) begin
         bad++;
         $display("FAIL timeout_cycle: got %0d want 33", c);
      end
      total++;
      if (bus.req_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_blocked_by_busy: got %b want 0", bus.req_ready);
      end
      stuck = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL timeout_idle: got ready=%b want 1", bus.req_ready);
      end
      @(negedge clk);
      total++;
      if ({bus.err_timeout, bus.req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL timeout_pulse: got err=%b ready=%b want 0 1", bus.err_timeout, bus.req_ready);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      reset         = 1'b1;
      stuck         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = MD_MULT;
      bus.req_rs    = 32'd0;
      bus.req_rt    = 32'd0;
      test_reset();
      test_mult();
      test_divu_hold();
      test_mt();
      test_back_to_back();
      test_div_zero();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
